// File: rtl/bus_cache_pkg.sv
// Shared constants and helpers for the direct-mapped write-through bus cache.
package bus_cache_pkg;

  localparam int LINE_WORDS = 4;
  localparam int OFF_BITS   = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL_REQ  = 3'd1,
    ST_FILL_WAIT = 3'd2,
    ST_FILL_DONE = 3'd3,
    ST_PASS_REQ  = 3'd4,
    ST_PASS_WAIT = 3'd5
  } state_t;

  function automatic logic is_cacheable(input logic [3:0] top_nibble, input logic [3:0] region);
    return (top_nibble == region);
  endfunction

endpackage

// File: rtl/cache_line_ram.sv
// Tag, valid and data storage: asynchronous read, synchronous word-granular write.
module cache_line_ram
  import bus_cache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 22
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] idx,
  input  logic [OFF_BITS-1:0]   rd_off,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [31:0]           rd_word,
  input  logic                  wr_en,
  input  logic [OFF_BITS-1:0]   wr_off,
  input  logic [31:0]           wr_data,
  input  logic                  tag_en,
  input  logic [TAG_BITS-1:0]   tag_data,
  input  logic                  inv_en
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_r;
  logic [TAG_BITS-1:0] tag_r  [LINES];
  logic [31:0]         data_r [LINES*LINE_WORDS];

  assign rd_valid = valid_r[idx];
  assign rd_tag   = tag_r[idx];
  assign rd_word  = data_r[{idx, rd_off}];

  // Valid bits: cleared together on reset, set on fill completion, cleared when a fill starts
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
    end else if (tag_en) begin
      valid_r[idx] <= 1'b1;
    end else if (inv_en) begin
      valid_r[idx] <= 1'b0;
    end
  end

  // Tag and data arrays carry no reset; valid gates their use
  always_ff @(posedge clk) begin
    if (tag_en) begin
      tag_r[idx] <= tag_data;
    end
    if (wr_en) begin
      data_r[{idx, wr_off}] <= wr_data;
    end
  end

endmodule

// File: rtl/bus_cache.sv
// Direct-mapped, write-through, no-write-allocate unified cache between core and system bus.
module bus_cache
  import bus_cache_pkg::*;
#(
  parameter int         INDEX_BITS   = 6,
  parameter logic [3:0] CACHE_REGION = 4'h2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] d,
  input  logic        we,
  input  logic        rd,
  output logic [31:0] spo,
  output logic        ready,
  output logic [31:0] m_a,
  output logic [31:0] m_d,
  output logic        m_we,
  output logic        m_rd,
  input  logic [31:0] m_spo,
  input  logic        m_ready
);

  localparam int TAG_BITS = 28 - INDEX_BITS;

  state_t                state_r, next_s;
  logic [31:0]           lat_a_r, lat_d_r;
  logic                  lat_we_r;
  logic [OFF_BITS-1:0]   cnt_r;

  logic [31:2]           addr_s;
  logic [INDEX_BITS-1:0] idx_s;
  logic [OFF_BITS-1:0]   off_s;
  logic [TAG_BITS-1:0]   tag_s;
  logic                  cacheable_s, hit_s;
  logic                  rd_valid_s;
  logic [TAG_BITS-1:0]   rd_tag_s;
  logic [31:0]           rd_word_s;
  logic [31:0]           fill_a_s;
  logic                  latch_s, cnt_clr_s, cnt_inc_s;
  logic                  wr_en_s, tag_en_s, inv_en_s;
  logic [OFF_BITS-1:0]   wr_off_s;
  logic [31:0]           wr_data_s;

  // Outside IDLE every lookup refers to the latched request
  assign addr_s      = (state_r == ST_IDLE) ? a[31:2] : lat_a_r[31:2];
  assign idx_s       = addr_s[3+INDEX_BITS:4];
  assign off_s       = addr_s[3:2];
  assign tag_s       = addr_s[31:4+INDEX_BITS];
  assign cacheable_s = is_cacheable(addr_s[31:28], CACHE_REGION);
  assign hit_s       = rd_valid_s && (rd_tag_s == tag_s);
  assign fill_a_s    = {lat_a_r[31:4], cnt_r, 2'b00};

  cache_line_ram #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .idx      (idx_s),
    .rd_off   (off_s),
    .rd_valid (rd_valid_s),
    .rd_tag   (rd_tag_s),
    .rd_word  (rd_word_s),
    .wr_en    (wr_en_s),
    .wr_off   (wr_off_s),
    .wr_data  (wr_data_s),
    .tag_en   (tag_en_s),
    .tag_data (tag_s),
    .inv_en   (inv_en_s)
  );

  // Next-state, core/bus outputs and storage write controls
  always_comb begin
    next_s    = state_r;
    ready     = 1'b0;
    spo       = 32'h0;
    m_a       = 32'h0;
    m_d       = 32'h0;
    m_rd      = 1'b0;
    m_we      = 1'b0;
    latch_s   = 1'b0;
    cnt_clr_s = 1'b0;
    cnt_inc_s = 1'b0;
    wr_en_s   = 1'b0;
    wr_off_s  = off_s;
    wr_data_s = 32'h0;
    tag_en_s  = 1'b0;
    inv_en_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ready = 1'b1;
        if (we) begin
          ready   = 1'b0;
          latch_s = 1'b1;
          next_s  = ST_PASS_REQ;
        end else if (rd) begin
          if (cacheable_s && hit_s) begin
            spo = rd_word_s;
          end else if (cacheable_s) begin
            // Invalidate up front so an abandoned fill never leaves a stale-tagged line
            ready     = 1'b0;
            latch_s   = 1'b1;
            cnt_clr_s = 1'b1;
            inv_en_s  = 1'b1;
            next_s    = ST_FILL_REQ;
          end else begin
            ready   = 1'b0;
            latch_s = 1'b1;
            next_s  = ST_PASS_REQ;
          end
        end else begin
          spo = 32'h0;
        end
      end
      ST_FILL_REQ, ST_FILL_WAIT: begin
        m_rd = (state_r == ST_FILL_REQ);
        m_a  = fill_a_s;
        if (m_ready) begin
          wr_en_s   = 1'b1;
          wr_off_s  = cnt_r;
          wr_data_s = m_spo;
          if (cnt_r == 2'd3) begin
            tag_en_s = 1'b1;
            next_s   = ST_FILL_DONE;
          end else begin
            cnt_inc_s = 1'b1;
            next_s    = ST_FILL_REQ;
          end
        end else begin
          next_s = ST_FILL_WAIT;
        end
      end
      ST_FILL_DONE: begin
        ready  = 1'b1;
        spo    = rd_word_s;
        next_s = ST_IDLE;
      end
      ST_PASS_REQ, ST_PASS_WAIT: begin
        m_a  = lat_a_r;
        m_d  = lat_d_r;
        m_we = (state_r == ST_PASS_REQ) && lat_we_r;
        m_rd = (state_r == ST_PASS_REQ) && !lat_we_r;
        if (m_ready) begin
          ready  = 1'b1;
          spo    = lat_we_r ? 32'h0 : m_spo;
          next_s = ST_IDLE;
          if (lat_we_r && cacheable_s && hit_s) begin
            wr_en_s   = 1'b1;
            wr_data_s = lat_d_r;
          end else begin
            wr_en_s = 1'b0;
          end
        end else begin
          next_s = ST_PASS_WAIT;
        end
      end
      default: begin
        next_s = ST_IDLE;
      end
    endcase
  end

  // State register, request latches and fill word counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      lat_a_r  <= 32'h0;
      lat_d_r  <= 32'h0;
      lat_we_r <= 1'b0;
      cnt_r    <= 2'd0;
    end else begin
      state_r <= next_s;
      if (latch_s) begin
        lat_a_r  <= a;
        lat_d_r  <= d;
        lat_we_r <= we;
      end
      if (cnt_clr_s) begin
        cnt_r <= 2'd0;
      end else if (cnt_inc_s) begin
        cnt_r <= cnt_r + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_bus_cache.sv
// Scoreboard bench for bus_cache: directed requests against a simple wait-state memory model.
module tb_bus_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a = 32'h0, d = 32'h0;
  logic        we = 1'b0, rd = 1'b0;
  logic [31:0] spo, m_a, m_d, m_spo;
  logic        ready, m_we, m_rd, m_ready;

  bus_cache dut (
    .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .rd(rd),
    .spo(spo), .ready(ready), .m_a(m_a), .m_d(m_d), .m_we(m_we), .m_rd(m_rd),
    .m_spo(m_spo), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] spo; int lat; } rsp_t;
  typedef struct { logic we; logic [31:0] a; logic [31:0] d; } ds_t;

  rsp_t exp_q[$];
  ds_t  ds_q[$];
  int   total = 0, bad = 0;
  int   issued = 0, done = 0;
  int   cyc = 0, issue_cyc = 0;

  // Memory model: unwritten words read back as their own address
  int          waits = 0;
  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] wr_a [8];
  logic [31:0] wr_d [8];
  int          wr_n = 0;

  function automatic logic [31:0] mem_val(input logic [31:0] addr);
    logic [31:0] v;
    v = addr;
    for (int i = 0; i < 8; i++) begin
      if (i < wr_n && wr_a[i] == addr) v = wr_d[i];
    end
    return v;
  endfunction

  always_comb begin
    m_spo = mem_val(m_a);
    if (m_rd || m_we) m_ready = (waits == 0);
    else              m_ready = mem_busy && (mem_cnt == 0);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if ((m_rd || m_we) && waits != 0) begin
      mem_busy <= 1'b1;
      mem_cnt  <= waits - 1;
    end else if (mem_busy && mem_cnt == 0) begin
      mem_busy <= 1'b0;
    end else if (mem_busy) begin
      mem_cnt <= mem_cnt - 1;
    end
    if (m_we) begin
      wr_a[wr_n] <= m_a;
      wr_d[wr_n] <= m_d;
      wr_n       <= wr_n + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Response monitor: completes the outstanding request on ready
  always @(negedge clk) begin
    if (issued != done && ready && exp_q.size() > 0) begin
      rsp_t r;
      r = exp_q.pop_front();
      chk("spo", spo, r.spo);
      chk("latency", 32'(cyc - issue_cyc), 32'(r.lat));
      done++;
    end
  end

  // Downstream monitor: every pulse must match the next expected bus transaction
  always @(negedge clk) begin
    if (m_rd || m_we) begin
      if (ds_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ds_unexpected: got a=%h we=%b required no transaction", m_a, m_we);
      end else begin
        ds_t e;
        e = ds_q.pop_front();
        chk("ds_a", m_a, e.a);
        chk("ds_we", {31'b0, m_we}, {31'b0, e.we});
        chk("ds_rd", {31'b0, m_rd}, {31'b0, !e.we});
        if (e.we) chk("ds_d", m_d, e.d);
      end
    end
  end

  task automatic push_ds(input logic w, input logic [31:0] addr, input logic [31:0] data);
    ds_t e;
    e.we = w; e.a = addr; e.d = data;
    ds_q.push_back(e);
  endtask

  task automatic push_fill(input logic [31:0] base);
    for (int i = 0; i < 4; i++) push_ds(1'b0, base + 32'(i * 4), 32'h0);
  endtask

  task automatic do_req(input logic [31:0] addr, input logic [31:0] data, input logic w,
                        input logic r, input logic [31:0] exp_spo, input int exp_lat);
    rsp_t e;
    int n;
    @(posedge clk); #1;
    a = addr; d = data; we = w; rd = r;
    e.spo = exp_spo; e.lat = exp_lat;
    exp_q.push_back(e);
    issue_cyc = cyc;
    issued++;
    @(posedge clk); #1;
    we = 1'b0; rd = 1'b0; d = 32'h0;
    n = 0;
    while (done != issued && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (done != issued) begin
      total++;
      bad++;
      $display("FAIL timeout: no ready for a=%h within %0d cycles", addr, n);
      exp_q.delete();
      done = issued;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'h1);
    chk("rst_spo", spo, 32'h0);
    chk("rst_m_rd", {31'b0, m_rd}, 32'h0);
    chk("rst_m_we", {31'b0, m_we}, 32'h0);
    chk("rst_m_a", m_a, 32'h0);
    chk("rst_m_d", m_d, 32'h0);

    // Cold miss then same-cycle hit in the filled line
    push_fill(32'h2000_0100);
    do_req(32'h2000_0104, 32'h0, 1'b0, 1'b1, 32'h2000_0104, 5);
    do_req(32'h2000_010C, 32'h0, 1'b0, 1'b1, 32'h2000_010C, 0);

    // Write hit updates the line and goes downstream
    push_ds(1'b1, 32'h2000_0108, 32'hDEAD_BEEF);
    do_req(32'h2000_0108, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 1);
    do_req(32'h2000_0108, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 0);

    // Write miss does not allocate
    push_ds(1'b1, 32'h2000_0400, 32'h1234_5678);
    do_req(32'h2000_0400, 32'h1234_5678, 1'b1, 1'b0, 32'h0, 1);
    push_fill(32'h2000_0400);
    do_req(32'h2000_0400, 32'h0, 1'b0, 1'b1, 32'h1234_5678, 5);

    // Uncached read with three wait cycles, twice
    waits = 3;
    push_ds(1'b0, 32'hF000_0000, 32'h0);
    do_req(32'hF000_0000, 32'h0, 1'b0, 1'b1, 32'hF000_0000, 4);
    push_ds(1'b0, 32'hF000_0000, 32'h0);
    do_req(32'hF000_0000, 32'h0, 1'b0, 1'b1, 32'hF000_0000, 4);
    waits = 0;

    // Conflict misses on index 0
    push_fill(32'h2000_0000);
    do_req(32'h2000_0000, 32'h0, 1'b0, 1'b1, 32'h2000_0000, 5);
    push_fill(32'h2000_0400);
    do_req(32'h2000_0408, 32'h0, 1'b0, 1'b1, 32'h2000_0408, 5);
    push_fill(32'h2000_0000);
    do_req(32'h2000_000C, 32'h0, 1'b0, 1'b1, 32'h2000_000C, 5);

    // One wait cycle per fill word doubles the downstream portion
    waits = 1;
    push_fill(32'h2000_0300);
    do_req(32'h2000_0308, 32'h0, 1'b0, 1'b1, 32'h2000_0308, 9);
    waits = 0;

    // Write and read together: write wins and updates the hit word
    push_ds(1'b1, 32'h2000_0104, 32'hCAFE_F00D);
    do_req(32'h2000_0104, 32'hCAFE_F00D, 1'b1, 1'b1, 32'h0, 1);
    do_req(32'h2000_0104, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 0);

    // Reset during the second fill word abandons the line
    push_ds(1'b0, 32'h2000_0200, 32'h0);
    push_ds(1'b0, 32'h2000_0204, 32'h0);
    @(posedge clk); #1;
    a = 32'h2000_0200; rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {31'b0, ready}, 32'h1);
    chk("midrst_m_rd", {31'b0, m_rd}, 32'h0);
    push_fill(32'h2000_0200);
    do_req(32'h2000_0200, 32'h0, 1'b0, 1'b1, 32'h2000_0200, 5);
    // Reset also cleared the earlier line
    push_fill(32'h2000_0100);
    do_req(32'h2000_010C, 32'h0, 1'b0, 1'b1, 32'h2000_010C, 5);

    repeat (4) @(posedge clk);
    chk("ds_left", 32'(ds_q.size()), 32'h0);
    chk("rsp_left", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
